// File: rtl/snitch_icache_miss_handler_if.sv
// Bundle of the lookup-result, response, refill and write-port channels
// around the instruction-cache miss handler.
interface snitch_icache_miss_handler_if #(
    parameter int unsigned FETCH_AW      = 32,
    parameter int unsigned LINE_WIDTH    = 128,
    parameter int unsigned LINE_ALIGN    = 4,
    parameter int unsigned COUNT_ALIGN   = 5,
    parameter int unsigned SET_ALIGN     = 1,
    parameter int unsigned ID_WIDTH      = 2,
    parameter int unsigned PENDING_COUNT = 2
);
    localparam int unsigned PIDX      = (PENDING_COUNT > 1) ? $clog2(PENDING_COUNT) : 1;
    localparam int unsigned TAG_WIDTH = FETCH_AW - LINE_ALIGN - COUNT_ALIGN;

    logic [FETCH_AW-1:0]    in_addr_i;
    logic [ID_WIDTH-1:0]    in_id_i;
    logic [SET_ALIGN-1:0]   in_set_i;
    logic                   in_hit_i;
    logic [LINE_WIDTH-1:0]  in_data_i;
    logic                   in_error_i;
    logic                   in_valid_i;
    logic                   in_ready_o;

    logic [LINE_WIDTH-1:0]  out_data_o;
    logic                   out_error_o;
    logic [ID_WIDTH-1:0]    out_id_o;
    logic                   out_valid_o;
    logic                   out_ready_i;

    logic [FETCH_AW-1:0]    refill_req_addr_o;
    logic [PIDX-1:0]        refill_req_id_o;
    logic                   refill_req_valid_o;
    logic                   refill_req_ready_i;

    logic [LINE_WIDTH-1:0]  refill_rsp_data_i;
    logic                   refill_rsp_error_i;
    logic [PIDX-1:0]        refill_rsp_id_i;
    logic                   refill_rsp_valid_i;
    logic                   refill_rsp_ready_o;

    logic [COUNT_ALIGN-1:0] write_addr_o;
    logic [SET_ALIGN-1:0]   write_set_o;
    logic [LINE_WIDTH-1:0]  write_data_o;
    logic [TAG_WIDTH-1:0]   write_tag_o;
    logic                   write_error_o;
    logic                   write_valid_o;
    logic                   write_ready_i;

    logic                   stall_full_o;

    modport slave (
        input  in_addr_i, in_id_i, in_set_i, in_hit_i, in_data_i, in_error_i, in_valid_i,
        output in_ready_o,
        output out_data_o, out_error_o, out_id_o, out_valid_o,
        input  out_ready_i,
        output refill_req_addr_o, refill_req_id_o, refill_req_valid_o,
        input  refill_req_ready_i,
        input  refill_rsp_data_i, refill_rsp_error_i, refill_rsp_id_i, refill_rsp_valid_i,
        output refill_rsp_ready_o,
        output write_addr_o, write_set_o, write_data_o, write_tag_o, write_error_o, write_valid_o,
        input  write_ready_i,
        output stall_full_o
    );

    modport master (
        output in_addr_i, in_id_i, in_set_i, in_hit_i, in_data_i, in_error_i, in_valid_i,
        input  in_ready_o,
        input  out_data_o, out_error_o, out_id_o, out_valid_o,
        output out_ready_i,
        input  refill_req_addr_o, refill_req_id_o, refill_req_valid_o,
        output refill_req_ready_i,
        output refill_rsp_data_i, refill_rsp_error_i, refill_rsp_id_i, refill_rsp_valid_i,
        input  refill_rsp_ready_o,
        input  write_addr_o, write_set_o, write_data_o, write_tag_o, write_error_o, write_valid_o,
        output write_ready_i,
        input  stall_full_o
    );
endinterface

// File: rtl/snitch_icache_miss_handler.sv
// Answers cache hits directly, coalesces misses in a small pending table,
// issues refills and writes returned lines back while answering all waiters.
module snitch_icache_miss_handler #(
    parameter int unsigned FETCH_AW      = 32,
    parameter int unsigned LINE_WIDTH    = 128,
    parameter int unsigned LINE_ALIGN    = 4,
    parameter int unsigned COUNT_ALIGN   = 5,
    parameter int unsigned SET_ALIGN     = 1,
    parameter int unsigned ID_WIDTH      = 2,
    parameter int unsigned PENDING_COUNT = 2
) (
    input logic                         clk_i,
    input logic                         rst_i,
    snitch_icache_miss_handler_if.slave bus
);
    localparam int unsigned PIDX   = (PENDING_COUNT > 1) ? $clog2(PENDING_COUNT) : 1;
    localparam int unsigned PSLOTS = 1 << PIDX;
    localparam int unsigned LAW    = FETCH_AW - LINE_ALIGN;

    logic [PENDING_COUNT-1:0] valid_q, valid_d;
    logic [LAW-1:0]           addr_q   [PENDING_COUNT];
    logic [LAW-1:0]           addr_d   [PENDING_COUNT];
    logic [ID_WIDTH-1:0]      idmask_q [PENDING_COUNT];
    logic [ID_WIDTH-1:0]      idmask_d [PENDING_COUNT];
    logic [SET_ALIGN-1:0]     way_q    [PENDING_COUNT];
    logic [SET_ALIGN-1:0]     way_d    [PENDING_COUNT];
    logic [SET_ALIGN-1:0]     cnt_q, cnt_d;

    logic [LAW-1:0]    in_line;
    logic [PSLOTS-1:0] valid_ext;
    logic              rsp_entry_valid;
    logic              match_found, free_found;
    logic [PIDX-1:0]   match_idx, free_idx;
    logic              unused_bits;

    assign in_line         = bus.in_addr_i[FETCH_AW-1:LINE_ALIGN];
    assign valid_ext       = PSLOTS'(valid_q);
    assign rsp_entry_valid = valid_ext[bus.refill_rsp_id_i];
    assign unused_bits     = ^{bus.in_set_i, bus.in_addr_i[LINE_ALIGN-1:0]};

    // Descending scan so the lowest matching / free index wins.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = PENDING_COUNT - 1; i >= 0; i--) begin
            if (valid_q[i] && (addr_q[i] == in_line)) begin
                match_found = 1'b1;
                match_idx   = PIDX'(i);
            end
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = PIDX'(i);
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        addr_d   = addr_q;
        idmask_d = idmask_q;
        way_d    = way_q;
        cnt_d    = cnt_q;

        bus.in_ready_o         = 1'b0;
        bus.out_data_o         = '0;
        bus.out_error_o        = 1'b0;
        bus.out_id_o           = '0;
        bus.out_valid_o        = 1'b0;
        bus.refill_req_addr_o  = '0;
        bus.refill_req_id_o    = '0;
        bus.refill_req_valid_o = 1'b0;
        bus.refill_rsp_ready_o = 1'b0;
        bus.write_addr_o       = '0;
        bus.write_set_o        = '0;
        bus.write_data_o       = '0;
        bus.write_tag_o        = '0;
        bus.write_error_o      = 1'b0;
        bus.write_valid_o      = 1'b0;
        bus.stall_full_o       = 1'b0;

        if (bus.refill_rsp_valid_i) begin
            // Write port and response port must complete together.
            if (rsp_entry_valid) begin
                bus.write_valid_o      = bus.out_ready_i;
                bus.out_valid_o        = bus.write_ready_i;
                bus.refill_rsp_ready_o = bus.write_ready_i & bus.out_ready_i;
                bus.write_addr_o       = addr_q[bus.refill_rsp_id_i][COUNT_ALIGN-1:0];
                bus.write_tag_o        = addr_q[bus.refill_rsp_id_i][LAW-1:COUNT_ALIGN];
                bus.write_set_o        = way_q[bus.refill_rsp_id_i];
                bus.write_data_o       = bus.refill_rsp_data_i;
                bus.write_error_o      = bus.refill_rsp_error_i;
                bus.out_data_o         = bus.refill_rsp_data_i;
                bus.out_error_o        = bus.refill_rsp_error_i;
                bus.out_id_o           = idmask_q[bus.refill_rsp_id_i];
                if (bus.write_ready_i && bus.out_ready_i) begin
                    valid_d[bus.refill_rsp_id_i]  = 1'b0;
                    idmask_d[bus.refill_rsp_id_i] = '0;
                end
            end else begin
                bus.refill_rsp_ready_o = 1'b1;
            end
        end else if (bus.in_valid_i) begin
            if (bus.in_hit_i) begin
                bus.out_valid_o = 1'b1;
                bus.out_data_o  = bus.in_data_i;
                bus.out_error_o = bus.in_error_i;
                bus.out_id_o    = bus.in_id_i;
                bus.in_ready_o  = bus.out_ready_i;
            end else if (match_found) begin
                bus.in_ready_o      = 1'b1;
                idmask_d[match_idx] = idmask_q[match_idx] | bus.in_id_i;
            end else if (free_found) begin
                bus.refill_req_valid_o = 1'b1;
                bus.refill_req_addr_o  = {in_line, {LINE_ALIGN{1'b0}}};
                bus.refill_req_id_o    = free_idx;
                bus.in_ready_o         = bus.refill_req_ready_i;
                if (bus.refill_req_ready_i) begin
                    valid_d[free_idx]  = 1'b1;
                    addr_d[free_idx]   = in_line;
                    idmask_d[free_idx] = bus.in_id_i;
                    way_d[free_idx]    = cnt_q;
                    cnt_d              = cnt_q + SET_ALIGN'(1);
                end
            end else begin
                bus.stall_full_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < PENDING_COUNT; i++) begin
                addr_q[i]   <= '0;
                idmask_q[i] <= '0;
                way_q[i]    <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            idmask_q <= idmask_d;
            way_q    <= way_d;
            cnt_q    <= cnt_d;
        end
    end

    refill_rsp_entry_valid: assert property (
        @(posedge clk_i) disable iff (rst_i) bus.refill_rsp_valid_i |-> rsp_entry_valid
    ) else $error("refill response for an invalid pending entry");

endmodule

// File: tb/tb_snitch_icache_miss_handler.sv
// Directed scenarios plus randomized traffic checked every cycle against a
// pending-table reference model of the miss handler.
module tb_snitch_icache_miss_handler;
    localparam int FAW = 32;
    localparam int LW  = 128;
    localparam int LA  = 4;
    localparam int CA  = 5;
    localparam int SA  = 1;
    localparam int IW  = 2;
    localparam int PC  = 2;
    localparam int LAW = FAW - LA;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snitch_icache_miss_handler_if bus ();
    snitch_icache_miss_handler dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: one slot per table entry, way derived from allocation count.
    bit             m_valid [PC];
    logic [LAW-1:0] m_line  [PC];
    logic [IW-1:0]  m_mask  [PC];
    int             m_way   [PC];
    int             m_allocs = 0;
    logic [SA-1:0]  ws_log [$];

    logic [LAW-1:0] rline;
    int             vq [$];
    logic [SA-1:0]  rr_exp [4];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        logic           e_in_rdy, e_out_v, e_req_v, e_rsp_rdy, e_wr_v, e_stall;
        logic [LW-1:0]  e_out_data;
        logic           e_out_err;
        logic [IW-1:0]  e_out_id;
        logic [FAW-1:0] e_req_addr;
        int             e_req_id, e_wr_addr, e_wr_tag, e_wr_set;
        int             k, match, free;
        bit             fire;
        logic [LAW-1:0] line;
        e_in_rdy = 0; e_out_v = 0; e_req_v = 0; e_rsp_rdy = 0; e_wr_v = 0; e_stall = 0;
        e_out_data = '0; e_out_err = 0; e_out_id = '0; e_req_addr = '0;
        e_req_id = 0; e_wr_addr = 0; e_wr_tag = 0; e_wr_set = 0;
        fire = 0; match = -1; free = -1;
        k = int'(bus.refill_rsp_id_i);
        line = bus.in_addr_i[FAW-1:LA];
        for (int i = 0; i < PC; i++) begin
            if (m_valid[i] && m_line[i] == line && match < 0) match = i;
            if (!m_valid[i] && free < 0) free = i;
        end
        if (bus.refill_rsp_valid_i) begin
            if (m_valid[k]) begin
                e_wr_v     = bus.out_ready_i;
                e_out_v    = bus.write_ready_i;
                e_rsp_rdy  = bus.out_ready_i & bus.write_ready_i;
                e_out_data = bus.refill_rsp_data_i;
                e_out_err  = bus.refill_rsp_error_i;
                e_out_id   = m_mask[k];
                e_wr_addr  = int'(m_line[k] % (1 << CA));
                e_wr_tag   = int'(m_line[k] >> CA);
                e_wr_set   = m_way[k];
                fire       = e_rsp_rdy;
            end else begin
                e_rsp_rdy = 1;
            end
        end else if (bus.in_valid_i && bus.in_hit_i) begin
            e_out_v    = 1;
            e_out_data = bus.in_data_i;
            e_out_err  = bus.in_error_i;
            e_out_id   = bus.in_id_i;
            e_in_rdy   = bus.out_ready_i;
        end else if (bus.in_valid_i) begin
            if (match >= 0) e_in_rdy = 1;
            else if (free >= 0) begin
                e_req_v    = 1;
                e_req_addr = FAW'(line) << LA;
                e_req_id   = free;
                e_in_rdy   = bus.refill_req_ready_i;
            end else e_stall = 1;
        end

        check_eq("in_ready", bus.in_ready_o, e_in_rdy);
        check_eq("out_valid", bus.out_valid_o, e_out_v);
        check_eq("refill_req_valid", bus.refill_req_valid_o, e_req_v);
        check_eq("refill_rsp_ready", bus.refill_rsp_ready_o, e_rsp_rdy);
        check_eq("write_valid", bus.write_valid_o, e_wr_v);
        check_eq("stall_full", bus.stall_full_o, e_stall);
        if (e_out_v) begin
            check_eq("out_data", bus.out_data_o, e_out_data);
            check_eq("out_error", bus.out_error_o, e_out_err);
            check_eq("out_id", bus.out_id_o, e_out_id);
        end
        if (e_req_v) begin
            check_eq("refill_req_addr", bus.refill_req_addr_o, e_req_addr);
            check_eq("refill_req_id", bus.refill_req_id_o, e_req_id);
        end
        if (e_wr_v) begin
            check_eq("write_addr", bus.write_addr_o, e_wr_addr);
            check_eq("write_tag", bus.write_tag_o, e_wr_tag);
            check_eq("write_set", bus.write_set_o, e_wr_set);
            check_eq("write_data", bus.write_data_o, e_out_data);
            check_eq("write_error", bus.write_error_o, e_out_err);
        end

        if (fire) ws_log.push_back(bus.write_set_o);
        if (rst) begin
            for (int i = 0; i < PC; i++) begin
                m_valid[i] = 0;
                m_mask[i]  = '0;
            end
            m_allocs = 0;
        end else if (fire) begin
            m_valid[k] = 0;
            m_mask[k]  = '0;
        end else if (!bus.refill_rsp_valid_i && bus.in_valid_i && !bus.in_hit_i) begin
            if (match >= 0) m_mask[match] = m_mask[match] | bus.in_id_i;
            else if (free >= 0 && bus.refill_req_ready_i) begin
                m_valid[free] = 1;
                m_line[free]  = line;
                m_mask[free]  = bus.in_id_i;
                m_way[free]   = m_allocs % (1 << SA);
                m_allocs++;
            end
        end
    endtask

    task automatic set_idle();
        bus.in_addr_i = '0; bus.in_id_i = '0; bus.in_set_i = '0; bus.in_hit_i = 0;
        bus.in_data_i = '0; bus.in_error_i = 0; bus.in_valid_i = 0;
        bus.refill_rsp_data_i = '0; bus.refill_rsp_error_i = 0;
        bus.refill_rsp_id_i = '0; bus.refill_rsp_valid_i = 0;
        bus.out_ready_i = 1; bus.refill_req_ready_i = 1; bus.write_ready_i = 1;
    endtask

    task automatic settle();
        #2;
        check_cycle();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic do_reset();
        rst = 1;
        set_idle();
        cyc();
        cyc();
        rst = 0;
    endtask

    task automatic miss(input logic [FAW-1:0] addr, input logic [IW-1:0] id);
        set_idle();
        bus.in_valid_i = 1; bus.in_hit_i = 0; bus.in_addr_i = addr; bus.in_id_i = id;
    endtask

    task automatic rsp(input int id, input logic [LW-1:0] data);
        set_idle();
        bus.refill_rsp_valid_i = 1; bus.refill_rsp_id_i = 1'(id); bus.refill_rsp_data_i = data;
    endtask

    initial begin
        set_idle();
        tick();
        tick();
        rst = 0;
        settle();
        check_eq("reset_out_valid", bus.out_valid_o, 0);
        check_eq("reset_req_valid", bus.refill_req_valid_o, 0);
        check_eq("reset_write_valid", bus.write_valid_o, 0);
        check_eq("reset_stall", bus.stall_full_o, 0);
        tick();

        // Hit answered in the same cycle.
        set_idle();
        bus.in_valid_i = 1; bus.in_hit_i = 1; bus.in_addr_i = 32'h1000_0040; bus.in_id_i = 2'b01;
        bus.in_data_i = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        settle();
        check_eq("hit_out_valid", bus.out_valid_o, 1);
        check_eq("hit_out_data", bus.out_data_o, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
        check_eq("hit_no_req", bus.refill_req_valid_o, 0);
        tick();

        // Miss, same-line coalesce, refill return.
        miss(32'h1000_0040, 2'b01);
        settle();
        check_eq("miss_req_addr", bus.refill_req_addr_o, 32'h1000_0040);
        check_eq("miss_req_id", bus.refill_req_id_o, 0);
        tick();
        miss(32'h1000_004C, 2'b10);
        settle();
        check_eq("coalesce_no_req", bus.refill_req_valid_o, 0);
        check_eq("coalesce_in_ready", bus.in_ready_o, 1);
        tick();
        rsp(0, 128'hAAAA_5555_0000_1111_2222_3333_4444_5555);
        settle();
        check_eq("refill_write_addr", bus.write_addr_o, 5'h04);
        check_eq("refill_write_tag", bus.write_tag_o, 23'h80000);
        check_eq("refill_write_set", bus.write_set_o, 0);
        check_eq("refill_out_id", bus.out_id_o, 2'b11);
        check_eq("refill_out_data", bus.out_data_o, 128'hAAAA_5555_0000_1111_2222_3333_4444_5555);
        tick();

        // Full table holds the third miss until an entry frees.
        do_reset();
        miss(32'h0000_1000, 2'b01); cyc();
        miss(32'h0000_2000, 2'b10); cyc();
        miss(32'h0000_3000, 2'b01);
        settle();
        check_eq("full_in_ready", bus.in_ready_o, 0);
        check_eq("full_stall", bus.stall_full_o, 1);
        tick();
        cyc();
        bus.refill_rsp_valid_i = 1; bus.refill_rsp_id_i = 1'b0;
        settle();
        check_eq("full_rsp_blocks_in", bus.in_ready_o, 0);
        tick();
        bus.refill_rsp_valid_i = 0;
        settle();
        check_eq("full_realloc_id", bus.refill_req_id_o, 0);
        tick();
        rsp(0, 128'h77);
        settle();
        check_eq("full_realloc_way", bus.write_set_o, 0);
        tick();
        rsp(1, 128'h88); cyc();

        // Refill with write backpressure outranks a hit.
        do_reset();
        miss(32'h0000_5000, 2'b01); cyc();
        rsp(0, 128'h5151);
        bus.in_valid_i = 1; bus.in_hit_i = 1; bus.in_addr_i = 32'h0000_6000;
        bus.in_id_i = 2'b10; bus.in_data_i = 128'h6262;
        bus.write_ready_i = 0;
        settle();
        check_eq("bp_rsp_ready", bus.refill_rsp_ready_o, 0);
        check_eq("bp_out_valid", bus.out_valid_o, 0);
        check_eq("bp_in_ready", bus.in_ready_o, 0);
        tick();
        bus.write_ready_i = 1;
        settle();
        check_eq("bp_rsp_done", bus.refill_rsp_ready_o, 1);
        tick();
        bus.refill_rsp_valid_i = 0;
        settle();
        check_eq("bp_hit_after", bus.out_data_o, 128'h6262);
        tick();

        // Round-robin way assignment across fresh allocations.
        do_reset();
        ws_log.delete();
        for (int i = 0; i < 4; i++) begin
            miss(32'h0000_7000 + 32'(i) * 32'h100, 2'b01); cyc();
            rsp(0, 128'(i)); cyc();
        end
        rr_exp = '{0, 1, 0, 1};
        check_eq("rr_count", ws_log.size(), 4);
        for (int i = 0; i < 4 && i < ws_log.size(); i++) check_eq("rr_way", ws_log[i], rr_exp[i]);

        // Randomized traffic with occasional mid-flight reset.
        for (int c = 0; c < 3000; c++) begin
            set_idle();
            rst = ($urandom_range(0, 199) == 0);
            rline = 28'h100_0000 + 28'($urandom_range(0, 5)) * 28'd37;
            bus.in_valid_i = ($urandom_range(0, 2) != 0);
            bus.in_hit_i   = ($urandom_range(0, 3) == 0);
            bus.in_addr_i  = {rline, 4'($urandom)};
            bus.in_id_i    = 2'($urandom_range(1, 3));
            bus.in_set_i   = 1'($urandom);
            bus.in_data_i  = {$urandom, $urandom, $urandom, $urandom};
            bus.in_error_i = 1'($urandom);
            vq.delete();
            for (int i = 0; i < PC; i++) if (m_valid[i]) vq.push_back(i);
            if (vq.size() > 0 && $urandom_range(0, 2) == 0) begin
                bus.refill_rsp_valid_i = 1;
                bus.refill_rsp_id_i    = 1'(vq[$urandom_range(0, vq.size() - 1)]);
                bus.refill_rsp_data_i  = {$urandom, $urandom, $urandom, $urandom};
                bus.refill_rsp_error_i = 1'($urandom);
            end
            bus.out_ready_i        = ($urandom_range(0, 3) != 0);
            bus.write_ready_i      = ($urandom_range(0, 3) != 0);
            bus.refill_req_ready_i = ($urandom_range(0, 3) != 0);
            cyc();
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
